// File: rtl/hd_pkg.sv
// rtl/hd_pkg.sv - shared constants and helpers for the hd elastic buffer
package hd_pkg;

    // Bit width needed to index n distinct values (never less than 1).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return (r < 1) ? 1 : r;
    endfunction

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return clog2(depth + 1);
    endfunction

    // A handshake transfer completes when both sides agree in the same cycle.
    function automatic logic fire(input logic valid, input logic ready);
        return valid & ready;
    endfunction

endpackage

// File: rtl/hd_wrap_ctr.sv
// rtl/hd_wrap_ctr.sv - modulo-(MAX+1) pointer counter with synchronous clear
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous return to zero, wins over inc
//   inc        : advance by one, wrapping MAX -> 0
//   value      : current count
module hd_wrap_ctr #(
    parameter int MAX   = 3,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);

    // Explicit compare against MAX so non-power-of-two depths wrap correctly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc) begin
            value <= (value == WIDTH'(MAX)) ? '0 : value + WIDTH'(1);
        end
    end

endmodule

// File: rtl/hd_elastic_buffer.sv
// rtl/hd_elastic_buffer.sv - multi-entry registered valid/ready elastic buffer
//
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   flush                : synchronous clear of all stored entries
//   in_data/valid/ready  : producer side
//   out_data/valid/ready : consumer side
//   count                : current occupancy, 0..DEPTH
//   almost_full          : count >= AFULL_LEVEL
module hd_elastic_buffer
    import hd_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 4,
    parameter int AFULL_LEVEL = DEPTH - 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [cnt_width(DEPTH)-1:0]   count,
    output logic                          almost_full
);

    localparam int CW = cnt_width(DEPTH);
    localparam int PW = clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  push;
    logic                  pop;

    // Both sides are derived from registered state only (plus flush on the
    // producer side), so no combinational path crosses the buffer. A full
    // buffer refuses even when the consumer pops in the same cycle.
    assign in_ready    = (count != CW'(DEPTH)) && !flush;
    assign out_valid   = (count != '0);
    assign out_data    = mem[rd_ptr];
    assign almost_full = (count >= CW'(AFULL_LEVEL));

    assign push = fire(in_valid, in_ready);
    assign pop  = fire(out_valid, out_ready);

    hd_wrap_ctr #(
        .MAX   (DEPTH - 1),
        .WIDTH (PW)
    ) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .inc   (push),
        .value (wr_ptr)
    );

    hd_wrap_ctr #(
        .MAX   (DEPTH - 1),
        .WIDTH (PW)
    ) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .inc   (pop),
        .value (rd_ptr)
    );

    // Flush empties the buffer; storage is left as-is since it is unreachable
    // until overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (push && !pop) begin
            count <= count + CW'(1);
        end else if (pop && !push) begin
            count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: doc/hd_elastic_buffer.md
Name: hd_elastic_buffer

Overview:
- Parametrised multi-entry valid/ready elastic buffer; next generation of the single-stage pipe/backup handshake sender.
- Sits between a producer and a consumer on any point-to-point handshake channel in the datapath.
- Breaks every combinational path from one side to the other: in_ready depends only on state and flush, never on out_ready; out_valid/out_data depend only on state.
- Adds depth, occupancy reporting, almost-full indication and synchronous flush.

Parameters:
DATA_WIDTH, 32, payload width in bits (>=1)
DEPTH, 4, number of storage entries (>=2; non-power-of-two allowed)
AFULL_LEVEL, DEPTH-1, occupancy at or above which almost_full asserts (1..DEPTH)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of all stored entries
in_data  in  DATA_WIDTH  producer payload
in_valid  in  1  producer offers in_data
in_ready  out  1  buffer can accept this cycle
out_data  out  DATA_WIDTH  head-of-queue payload
out_valid  out  1  head entry present
out_ready  in  1  consumer accepts head this cycle
count  out  CW=clog2(DEPTH+1)  current occupancy
almost_full  out  1  count >= AFULL_LEVEL

Behaviour:
- Reset: clk and rst_n as named above; reset is asynchronous, active-low.
  - On rst_n low: count=0, wr_ptr=rd_ptr=0, all storage entries=0.
  - So out_valid=0, out_data=0, in_ready=1, almost_full=0 (AFULL_LEVEL>=1).
  - Reset may assert mid-transfer; in-flight entries are discarded with no handshake completion.
- Push: in_valid && in_ready at rising edge. Writes mem[wr_ptr], then wr_ptr advances.
- Pop: out_valid && out_ready at rising edge. rd_ptr advances.
- in_ready = (count != DEPTH) && !flush. No dependence on out_ready. A full buffer refuses a push even when a pop occurs in the same cycle.
- out_valid = (count != 0). out_data = mem[rd_ptr]. No fall-through: a word pushed at edge N is visible at out_* after edge N; minimum latency 1 cycle.
- Throughput: 1 word/cycle sustained whenever 0 < count < DEPTH.
- Simultaneous push and pop (count not 0, not DEPTH): count unchanged, both pointers advance.
- Pointers: wrap from DEPTH-1 to 0 explicitly, with no power-of-two assumption.
- Count update: +1 on push only, -1 on pop only, unchanged otherwise. It never exceeds DEPTH and never underflows.
- flush (synchronous): has priority over push and pop. At the edge: count=0, pointers=0; storage contents are don't-care. Any pop in the flush cycle counts as completed; the push is refused because in_ready=0.
- Stability guarantee: while out_valid && !out_ready, out_data and out_valid are held unchanged (flush excepted).
- Upstream contract: in_valid/in_data held until accepted. The bench asserts this; the RTL does not check it.
- almost_full: combinational from the count register only.

Decomposition:
- Package hd_pkg:
  - clog2 constant function.
  - CW width constant derivation.
  - Shared handshake fire helper (valid && ready).
- Sub-module hd_wrap_ctr (parameters MAX, WIDTH; inputs inc and clr; output value), used for wr_ptr and rd_ptr.
- Storage is an inline register array, not a separate module.

Test Plan:
- Reset then idle, DEPTH=4, out_ready=0. Push 0xA0..0xA3 on consecutive cycles -> in_ready drops after 4th push; count=4; almost_full=1 from count=3; out_data=0xA0 held stable.
- Full buffer, out_ready=1, in_valid=1 with 0xB0 -> pop 0xA0 that cycle, push refused; next cycle count=3, in_ready=1, 0xB0 then accepted.
- Continuous stream of 0..99, in_valid=out_ready=1 -> output order 0..99, one per cycle after 1-cycle latency; count stays 1.
- DEPTH=3 (non-power-of-two), 10 pushes/pops with random stalls -> pointers wrap 2->0; data order preserved; count never exceeds 3.
- flush asserted with count=3 and in_valid=1 -> in_ready=0 that cycle; next cycle count=0, out_valid=0; the pushed word does not appear.
- rst_n pulsed low asynchronously (between edges) with count=2 -> out_valid=0 and count=0 immediately; buffer resumes correctly after release.
